// File: rtl/uart_inst_loader.sv
// uart_inst_loader: boot-time front end of the core.
// Receives 8N1 UART frames (LSB first) and packs them, MSB byte first, into 32-bit words.
// Each word goes to instruction memory from address 0 until the delimiter 0xFFFFFFFF arrives.
// After the delimiter, LOAD_DONE is raised and every later byte is passed on as a
// valid/ready byte stream.
//
// Ports:
//   CLK           system clock
//   INITIALIZE_N  asynchronous active-low reset
//   UART_RX       asynchronous serial input, idle high
//   IMEM_WE       one-cycle instruction-memory write strobe
//   IMEM_ADDR     word address of the write (held until the next write)
//   IMEM_WDATA    instruction word (held until the next write)
//   LOAD_DONE     sticky, delimiter received
//   INST_COUNT    number of words written
//   RX_VALID      stream byte available
//   RX_DATA       stream byte
//   RX_READY      consumer takes the byte when RX_VALID && RX_READY
//   FRAMING_ERR   sticky, a stop bit was sampled low
//   OVERRUN       sticky, a stream byte was dropped
//   OVERFLOW      sticky, an instruction word was dropped because memory was full
module uart_inst_loader #(
    parameter int unsigned T      = 130,
    parameter int unsigned ADDR_W = 14
) (
    input  logic              CLK,
    input  logic              INITIALIZE_N,
    input  logic              UART_RX,
    output logic              IMEM_WE,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    output logic [31:0]       IMEM_WDATA,
    output logic              LOAD_DONE,
    output logic [ADDR_W:0]   INST_COUNT,
    output logic              RX_VALID,
    output logic [7:0]        RX_DATA,
    input  logic              RX_READY,
    output logic              FRAMING_ERR,
    output logic              OVERRUN,
    output logic              OVERFLOW
);

    localparam logic [15:0] HalfM1 = 16'((T / 2) - 1);
    localparam logic [15:0] FullM1 = 16'(T - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} rx_state_e;
    typedef enum logic {StLoad, StStream} ld_state_e;

    // ---------------- input synchroniser and edge detect ----------------
    // Reset to 0, not idle-high. If the line is still low mid-frame when reset is
    // released, this value means no falling edge is seen.
    logic rx_s1_q, rx_s2_q, rx_prev_q;
    logic rx_fall;

    always_ff @(posedge CLK or negedge INITIALIZE_N) begin
        if (!INITIALIZE_N) begin
            rx_s1_q   <= 1'b0;
            rx_s2_q   <= 1'b0;
            rx_prev_q <= 1'b0;
        end else begin
            rx_s1_q   <= UART_RX;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_s2_q;

    // ---------------- receiver ----------------
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        byte_evt_q, byte_evt_d;
    logic        ferr_q, ferr_d;

    always_ff @(posedge CLK or negedge INITIALIZE_N) begin
        if (!INITIALIZE_N) begin
            rx_state_q <= StIdle;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_evt_q <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            byte_evt_q <= byte_evt_d;
            ferr_q     <= ferr_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_evt_d = 1'b0;
        ferr_d     = ferr_q;
        case (rx_state_q)
            StIdle: begin
                if (rx_fall) begin
                    cnt_d      = HalfM1;
                    rx_state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == 16'd0) begin
                    if (!rx_s2_q) begin
                        cnt_d      = FullM1;
                        bit_d      = 3'd0;
                        rx_state_d = StData;
                    end else begin
                        rx_state_d = StIdle;  // glitch shorter than half a bit
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StData: begin
                if (cnt_q == 16'd0) begin
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    cnt_d   = FullM1;
                    if (bit_q == 3'd7) begin
                        rx_state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            StStop: begin
                if (cnt_q == 16'd0) begin
                    // Return to idle mid stop bit so the next start edge is not missed.
                    if (rx_s2_q) begin
                        byte_evt_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    rx_state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: rx_state_d = StIdle;
        endcase
    end

    // ---------------- loader / stream ----------------
    // shift_q stays stable for at least half a bit after the byte event, so the
    // loader reads it directly.
    ld_state_e         ld_state_q, ld_state_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       word_q, word_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              done_q, done_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              vld_q, vld_d;
    logic [7:0]        data_q, data_d;
    logic              ovr_q, ovr_d;
    logic [31:0]       full_word;

    always_ff @(posedge CLK or negedge INITIALIZE_N) begin
        if (!INITIALIZE_N) begin
            ld_state_q <= StLoad;
            idx_q      <= '0;
            word_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            vld_q      <= 1'b0;
            data_q     <= '0;
            ovr_q      <= 1'b0;
        end else begin
            ld_state_q <= ld_state_d;
            idx_q      <= idx_d;
            word_q     <= word_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            vld_q      <= vld_d;
            data_q     <= data_d;
            ovr_q      <= ovr_d;
        end
    end

    always_comb begin
        ld_state_d = ld_state_q;
        idx_d      = idx_q;
        word_d     = word_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        done_d     = done_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        vld_d      = vld_q;
        data_d     = data_q;
        ovr_d      = ovr_q;
        full_word  = {word_q, shift_q};
        case (ld_state_q)
            StLoad: begin
                if (byte_evt_q) begin
                    if (idx_q == 2'd3) begin
                        idx_d = 2'd0;
                        if (full_word == 32'hFFFF_FFFF) begin
                            done_d     = 1'b1;
                            ld_state_d = StStream;
                        end else if (!count_q[ADDR_W]) begin
                            we_d    = 1'b1;
                            addr_d  = count_q[ADDR_W-1:0];
                            wdata_d = full_word;
                            count_d = count_q + 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        idx_d  = idx_q + 2'd1;
                        word_d = full_word[23:0];
                    end
                end
            end
            StStream: begin
                if (byte_evt_q) begin
                    if (vld_q && !RX_READY) begin
                        ovr_d = 1'b1;  // keep the unconsumed byte, drop the new one
                    end else begin
                        vld_d  = 1'b1;
                        data_d = shift_q;
                    end
                end else if (vld_q && RX_READY) begin
                    vld_d = 1'b0;
                end
            end
            default: ld_state_d = StLoad;
        endcase
    end

    assign IMEM_WE     = we_q;
    assign IMEM_ADDR   = addr_q;
    assign IMEM_WDATA  = wdata_q;
    assign LOAD_DONE   = done_q;
    assign INST_COUNT  = count_q;
    assign RX_VALID    = vld_q;
    assign RX_DATA     = data_q;
    assign FRAMING_ERR = ferr_q;
    assign OVERRUN     = ovr_q;
    assign OVERFLOW    = ovf_q;

endmodule

// File: tb/tb_uart_inst_loader.sv
module tb_uart_inst_loader;

    localparam int unsigned T      = 16;
    localparam int unsigned ADDR_W = 14;

    logic              CLK = 1'b0;
    logic              INITIALIZE_N = 1'b0;
    logic              UART_RX = 1'b1;
    logic              IMEM_WE;
    logic [ADDR_W-1:0] IMEM_ADDR;
    logic [31:0]       IMEM_WDATA;
    logic              LOAD_DONE;
    logic [ADDR_W:0]   INST_COUNT;
    logic              RX_VALID;
    logic [7:0]        RX_DATA;
    logic              RX_READY = 1'b0;
    logic              FRAMING_ERR;
    logic              OVERRUN;
    logic              OVERFLOW;

    int total = 0;
    int bad   = 0;

    // Write log filled by the monitor below
    int          wr_total = 0;
    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];

    uart_inst_loader #(.T(T), .ADDR_W(ADDR_W)) dut (
        .CLK         (CLK),
        .INITIALIZE_N(INITIALIZE_N),
        .UART_RX     (UART_RX),
        .IMEM_WE     (IMEM_WE),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_WDATA  (IMEM_WDATA),
        .LOAD_DONE   (LOAD_DONE),
        .INST_COUNT  (INST_COUNT),
        .RX_VALID    (RX_VALID),
        .RX_DATA     (RX_DATA),
        .RX_READY    (RX_READY),
        .FRAMING_ERR (FRAMING_ERR),
        .OVERRUN     (OVERRUN),
        .OVERFLOW    (OVERFLOW)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (IMEM_WE === 1'b1) begin
            wr_addr[wr_total % 64] = 32'(IMEM_ADDR);
            wr_data[wr_total % 64] = IMEM_WDATA;
            wr_total = wr_total + 1;
        end
    end

    task automatic idle(input int n);
        UART_RX = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic drive_bit(input logic b);
        UART_RX = b;
        repeat (T) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        UART_RX = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24], 1'b1);
        send_byte(w[23:16], 1'b1);
        send_byte(w[15:8], 1'b1);
        send_byte(w[7:0], 1'b1);
    endtask

    task automatic do_reset();
        UART_RX      = 1'b1;
        RX_READY     = 1'b0;
        @(negedge CLK);
        INITIALIZE_N = 1'b0;
        repeat (3) @(negedge CLK);
        INITIALIZE_N = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({IMEM_WE, IMEM_ADDR, IMEM_WDATA, LOAD_DONE, INST_COUNT, RX_VALID, RX_DATA,
             FRAMING_ERR, OVERRUN, OVERFLOW} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got we=%b addr=%h wdata=%h done=%b cnt=%0d vld=%b data=%h fe=%b ov=%b of=%b, want all 0",
                     IMEM_WE, IMEM_ADDR, IMEM_WDATA, LOAD_DONE, INST_COUNT, RX_VALID, RX_DATA,
                     FRAMING_ERR, OVERRUN, OVERFLOW);
        end
    endtask

    task automatic test_load();
        int base;
        do_reset();
        base = wr_total;
        send_word(32'hA400_0000);
        send_word(32'hC800_0000);
        send_word(32'hFFFF_FFFF);
        idle(2 * T);
        total++;
        if (wr_total - base !== 2) begin
            bad++;
            $display("FAIL load_write_count: got %0d want 2", wr_total - base);
        end
        total++;
        if (wr_addr[base % 64] !== 32'd0 || wr_data[base % 64] !== 32'hA400_0000) begin
            bad++;
            $display("FAIL load_write0: got addr=%0d data=%h want addr=0 data=a4000000",
                     wr_addr[base % 64], wr_data[base % 64]);
        end
        total++;
        if (wr_addr[(base + 1) % 64] !== 32'd1 || wr_data[(base + 1) % 64] !== 32'hC800_0000) begin
            bad++;
            $display("FAIL load_write1: got addr=%0d data=%h want addr=1 data=c8000000",
                     wr_addr[(base + 1) % 64], wr_data[(base + 1) % 64]);
        end
        total++;
        if (LOAD_DONE !== 1'b1 || INST_COUNT !== 15'd2) begin
            bad++;
            $display("FAIL load_done_count: got done=%b cnt=%0d want done=1 cnt=2",
                     LOAD_DONE, INST_COUNT);
        end
    endtask

    task automatic test_stream();
        int base;
        do_reset();
        base = wr_total;
        send_word(32'hFFFF_FFFF);
        idle(T);
        total++;
        if (wr_total - base !== 0 || LOAD_DONE !== 1'b1) begin
            bad++;
            $display("FAIL stream_delim: got writes=%0d done=%b want writes=0 done=1",
                     wr_total - base, LOAD_DONE);
        end
        send_byte(8'h41, 1'b1);
        idle(4);
        total++;
        if (RX_VALID !== 1'b1 || RX_DATA !== 8'h41) begin
            bad++;
            $display("FAIL stream_byte: got vld=%b data=%h want vld=1 data=41", RX_VALID, RX_DATA);
        end
        RX_READY = 1'b1;
        @(negedge CLK);
        RX_READY = 1'b0;
        total++;
        if (RX_VALID !== 1'b0 || OVERRUN !== 1'b0) begin
            bad++;
            $display("FAIL stream_handshake: got vld=%b ovr=%b want vld=0 ovr=0", RX_VALID, OVERRUN);
        end
    endtask

    task automatic test_overrun();
        // Continues in STREAM from test_stream, RX_READY low
        send_byte(8'h41, 1'b1);
        send_byte(8'h42, 1'b1);
        idle(T);
        total++;
        if (RX_VALID !== 1'b1 || RX_DATA !== 8'h41 || OVERRUN !== 1'b1) begin
            bad++;
            $display("FAIL overrun: got vld=%b data=%h ovr=%b want vld=1 data=41 ovr=1",
                     RX_VALID, RX_DATA, OVERRUN);
        end
    endtask

    task automatic test_framing();
        int base;
        do_reset();
        base = wr_total;
        send_byte(8'h55, 1'b0);
        idle(T);
        total++;
        if (FRAMING_ERR !== 1'b1) begin
            bad++;
            $display("FAIL framing_flag: got %b want 1", FRAMING_ERR);
        end
        send_word(32'h1234_5678);
        idle(T);
        total++;
        if (wr_total - base !== 1 || wr_data[base % 64] !== 32'h1234_5678 ||
            wr_addr[base % 64] !== 32'd0) begin
            bad++;
            $display("FAIL framing_write: got writes=%0d addr=%0d data=%h want 1 write addr=0 data=12345678",
                     wr_total - base, wr_addr[base % 64], wr_data[base % 64]);
        end
        total++;
        if (INST_COUNT !== 15'd1 || FRAMING_ERR !== 1'b1) begin
            bad++;
            $display("FAIL framing_count: got cnt=%0d fe=%b want cnt=1 fe=1", INST_COUNT, FRAMING_ERR);
        end
    endtask

    task automatic test_glitch();
        int base;
        do_reset();
        base = wr_total;
        UART_RX = 1'b0;
        repeat (2) @(negedge CLK);
        idle(3 * T);
        total++;
        if (RX_VALID !== 1'b0 || FRAMING_ERR !== 1'b0 || OVERRUN !== 1'b0 ||
            OVERFLOW !== 1'b0 || INST_COUNT !== 15'd0) begin
            bad++;
            $display("FAIL glitch_flags: got vld=%b fe=%b ovr=%b of=%b cnt=%0d want all 0",
                     RX_VALID, FRAMING_ERR, OVERRUN, OVERFLOW, INST_COUNT);
        end
        // The glitch must not have advanced the byte index
        send_word(32'hAABB_CCDD);
        idle(T);
        total++;
        if (wr_total - base !== 1 || wr_data[base % 64] !== 32'hAABB_CCDD) begin
            bad++;
            $display("FAIL glitch_word: got writes=%0d data=%h want 1 write data=aabbccdd",
                     wr_total - base, wr_data[base % 64]);
        end
    endtask

    task automatic test_reset_midframe();
        int          base;
        logic [7:0]  b;
        do_reset();
        send_word(32'h0102_0304);
        idle(T);
        total++;
        if (INST_COUNT !== 15'd1) begin
            bad++;
            $display("FAIL midreset_pre: got cnt=%0d want 1", INST_COUNT);
        end
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        // Third byte 0xF0: abort during data bit 2 (low)
        b = 8'hF0;
        drive_bit(1'b0);
        drive_bit(b[0]);
        drive_bit(b[1]);
        UART_RX = b[2];
        repeat (T / 2) @(negedge CLK);
        INITIALIZE_N = 1'b0;
        #1;
        total++;
        if ({IMEM_WE, IMEM_ADDR, IMEM_WDATA, LOAD_DONE, INST_COUNT, RX_VALID, RX_DATA,
             FRAMING_ERR, OVERRUN, OVERFLOW} !== '0) begin
            bad++;
            $display("FAIL midreset_async: got we=%b addr=%h wdata=%h done=%b cnt=%0d want all 0",
                     IMEM_WE, IMEM_ADDR, IMEM_WDATA, LOAD_DONE, INST_COUNT);
        end
        repeat (T / 2) @(negedge CLK);
        INITIALIZE_N = 1'b1;
        // Remainder of the aborted frame: bit3 low, bits 4..7 high, stop high
        for (int i = 3; i < 8; i++) drive_bit(b[i]);
        drive_bit(1'b1);
        idle(2 * T);
        base = wr_total;
        send_word(32'hDEAD_BEEF);
        idle(T);
        total++;
        if (wr_total - base !== 1 || wr_addr[base % 64] !== 32'd0 ||
            wr_data[base % 64] !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL midreset_word: got writes=%0d addr=%0d data=%h want 1 write addr=0 data=deadbeef",
                     wr_total - base, wr_addr[base % 64], wr_data[base % 64]);
        end
        total++;
        if (INST_COUNT !== 15'd1 || FRAMING_ERR !== 1'b0) begin
            bad++;
            $display("FAIL midreset_count: got cnt=%0d fe=%b want cnt=1 fe=0", INST_COUNT, FRAMING_ERR);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_stream();
        test_overrun();
        test_framing();
        test_glitch();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_inst_loader.md
# uart_inst_loader

Boot-time front end of the core: deserialises the host UART line (8N1, LSB first, bytes of a word sent MSB byte first), packs bytes into 32-bit instruction words and writes them to instruction memory from address 0 up until the delimiter word 0xFFFFFFFF. After the delimiter it raises LOAD_DONE and forwards every later byte as a byte stream for the core's read-input instructions. It sits between the UART_RX pin and the CPU's instruction-memory write port and input-byte consumer.

## Interface

- T, 130: clock cycles per UART bit; legal range 4..65535.
- ADDR_W, 14: instruction-memory word-address width.

- CLK  in  1  system clock.
- INITIALIZE_N  in  1  asynchronous active-low reset.
- UART_RX  in  1  asynchronous serial input, idle high.
- IMEM_WE  out  1  one-cycle write strobe.
- IMEM_ADDR  out  ADDR_W  word address of the write.
- IMEM_WDATA  out  32  instruction word.
- LOAD_DONE  out  1  set once the delimiter is received; sticky.
- INST_COUNT  out  ADDR_W+1  number of words written.
- RX_VALID  out  1  stream byte available.
- RX_DATA  out  8  stream byte.
- RX_READY  in  1  consumer takes byte when RX_VALID && RX_READY.
- FRAMING_ERR  out  1  sticky: a stop bit sampled low.
- OVERRUN  out  1  sticky: stream byte dropped.
- OVERFLOW  out  1  sticky: instruction word dropped, memory full.

## Operation

- Reset: all outputs 0; receiver IDLE, loader LOAD, byte index 0, word count 0.
- Input sync: UART_RX passes through 2 flops; all sampling uses the synchronised value.
- Receiver FSM: IDLE -> START on a synced 1->0 edge; START waits T/2 (floor) cycles, samples: low -> DATA, high -> IDLE (glitch, nothing reported); DATA samples 8 bits at T-cycle intervals, LSB first; STOP samples after T more cycles: high -> byte event, low -> FRAMING_ERR set, byte discarded; both -> IDLE immediately (mid stop bit), so back-to-back frames are received.
- Loader, state LOAD: byte index 0..3 shifts bytes into the word MSB first; a framing error does not advance the index. On the 4th byte:
  - word == 0xFFFFFFFF -> no write, LOAD_DONE=1, state STREAM, index 0.
  - else if INST_COUNT < 2^ADDR_W -> IMEM_WE=1, IMEM_ADDR=INST_COUNT[ADDR_W-1:0], IMEM_WDATA=word, INST_COUNT+1.
  - else -> word dropped, OVERFLOW=1, no write.
- Loader, state STREAM: each byte event loads RX_DATA and sets RX_VALID. RX_VALID holds until a handshake.
  - Byte event with RX_VALID && !RX_READY -> new byte dropped, old byte kept, OVERRUN=1.
  - Byte event in the same cycle as a handshake -> new byte loaded, RX_VALID stays 1.
  - Handshake with no byte event -> RX_VALID=0.
- STREAM is left only by reset. The sticky flags and INST_COUNT clear only on reset.
- Reset mid-frame: all state aborts at once. After release the receiver waits for a new 1->0 edge, so the remainder of a partial frame does not start a new frame, except a 1->0 transition inside that remainder.

## Timing

- Byte event: asserted the cycle after the stop-bit sample. The stop sample falls 2 + T/2 + 9T cycles after the RX falling edge, plus or minus one cycle of sync skew.
- IMEM_WE, LOAD_DONE, RX_VALID and RX_DATA are registered and change the cycle after the byte event.
- IMEM_WE is high exactly 1 cycle per written word. IMEM_ADDR and IMEM_WDATA are valid in that cycle and hold until the next write.
- INST_COUNT updates in the same cycle as IMEM_WE.
- Throughput: 1 byte per 10T cycles. No backpressure to the host in either state.

## Test plan

- Send words 0xA4000000, 0xC8000000, 0xFFFFFFFF as 12 frames with T=16 -> two IMEM_WE pulses: (addr 0, 0xA4000000) and (addr 1, 0xC8000000). LOAD_DONE=1 after the last frame; INST_COUNT=2.
- Send 0xFFFFFFFF first -> no IMEM_WE and LOAD_DONE=1. Then send byte 0x41 with RX_READY=0 -> RX_VALID=1, RX_DATA=0x41. Raise RX_READY for 1 cycle -> RX_VALID=0.
- In STREAM with RX_READY=0, send 0x41 then 0x42 -> RX_DATA stays 0x41 and OVERRUN=1.
- Send a frame with stop bit 0, then bytes 12 34 56 78 -> FRAMING_ERR=1 and exactly one write of 0x12345678.
- Drive a 2-cycle low pulse on UART_RX with T=16 -> no byte event and no flag set.
- Pull INITIALIZE_N low during a data bit of byte 3 of a word -> all outputs 0 immediately. A following clean word is written at address 0.
